// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and
// writes them to consecutive instruction memory addresses while stalling the core.
module imem_boot_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    // Byte handshake: a byte transfers on a cycle where byte_valid and
    // byte_ready are both high; byte_ready is high only in LOAD.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                load_err_q, load_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        load_err_d = load_err_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_stall  = 1'b0;
        load_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start && (load_len != '0)) begin
                    len_d      = (load_len > DEPTH_L) ? DEPTH_L : load_len;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    load_err_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                cpu_stall  = 1'b1;
                if (abort) begin
                    // Any partially assembled word is simply dropped.
                    load_err_d = 1'b1;
                    state_d    = IDLE;
                end else if (byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: begin
                            // mem_wdata only changes when a whole word is ready.
                            wdata_d = {byte_data, asm_q};
                            state_d = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                cpu_stall = 1'b1;
                if (abort) begin
                    load_err_d = 1'b1;
                    state_d    = IDLE;
                end else if ({1'b0, word_cnt_q} == (len_q - ONE_L)) begin
                    state_d = DONE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    byte_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            DONE: begin
                load_done = 1'b1;
                cpu_stall = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign mem_waddr = word_cnt_q;
    assign mem_wdata = wdata_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table-driven load scenarios plus hand-written
// timing, abort and reset sequences, with a write scoreboard.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [8:0]  load_len;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [39:0] exp_q[$];

  typedef struct {
    int len;
    int gap;
    int abort_after;
    int exp_writes;
    bit exp_err;
    bit exp_done;
  } vec_t;

  vec_t vecs[9];

  imem_boot_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write is popped against the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_waddr, mem_wdata);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check("write_addr_data", {24'd0, mem_waddr, mem_wdata}, {24'd0, e});
        end
        check("ready_low_in_write", byte_ready, 1'b0);
      end
      if (load_done) done_cnt++;
    end
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic start_load(input logic [8:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("byte_ready_timeout", byte_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int clamp, nbytes, wr0, dn0;
    logic [31:0] word;
    clamp  = (v.len > 256) ? 256 : v.len;
    nbytes = (v.abort_after >= 0) ? v.abort_after : clamp * 4;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    word = '0;
    start_load(9'(v.len));
    @(negedge clk);
    check($sformatf("vec%0d_busy", idx), busy, 1'b1);
    check($sformatf("vec%0d_err_cleared", idx), load_err, 1'b0);
    @(posedge clk); #1;
    for (int b = 0; b < nbytes; b++) begin
      if (b % 4 == 0) begin
        word = $urandom;
        if (b / 4 < nbytes / 4) exp_q.push_back({8'(b / 4), word});
      end
      send_byte(word[8*(b%4) +: 8], v.gap);
    end
    byte_valid = 1'b0;
    if (v.abort_after >= 0) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    wait_idle();
    check($sformatf("vec%0d_writes", idx), 64'(wr_cnt - wr0), 64'(v.exp_writes));
    check($sformatf("vec%0d_done", idx), 64'(done_cnt - dn0), 64'(v.exp_done));
    check($sformatf("vec%0d_err", idx), load_err, v.exp_err);
    check($sformatf("vec%0d_stall", idx), cpu_stall, 1'b0);
    check($sformatf("vec%0d_queue_empty", idx), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit seen;
    int wr0, dn0;

    vecs[0] = '{len: 2,   gap: 0, abort_after: -1, exp_writes: 2,   exp_err: 0, exp_done: 1};
    vecs[1] = '{len: 2,   gap: 1, abort_after: -1, exp_writes: 2,   exp_err: 0, exp_done: 1};
    vecs[2] = '{len: 1,   gap: 3, abort_after: -1, exp_writes: 1,   exp_err: 0, exp_done: 1};
    vecs[3] = '{len: 300, gap: 0, abort_after: -1, exp_writes: 256, exp_err: 0, exp_done: 1};
    vecs[4] = '{len: 2,   gap: 0, abort_after: 6,  exp_writes: 1,   exp_err: 1, exp_done: 0};
    vecs[5] = '{len: 5,   gap: 2, abort_after: -1, exp_writes: 5,   exp_err: 0, exp_done: 1};
    vecs[6] = '{len: 3,   gap: 0, abort_after: 4,  exp_writes: 1,   exp_err: 1, exp_done: 0};
    vecs[7] = '{len: 2,   gap: 0, abort_after: 2,  exp_writes: 0,   exp_err: 1, exp_done: 0};
    vecs[8] = '{len: 256, gap: 0, abort_after: -1, exp_writes: 256, exp_err: 0, exp_done: 1};

    reset = 1'b1; load_start = 1'b0; load_len = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_outputs",
          {56'd0, byte_ready, mem_we, cpu_stall, busy, load_done, load_err, 2'b00}, 64'd0);
    check("rst_addr_data", {24'd0, mem_waddr, mem_wdata}, 64'd0);
    @(posedge clk); #1;

    // directed 2-word load with stall/done timing
    exp_q.push_back({8'd0, 32'h12345678});
    exp_q.push_back({8'd1, 32'h9ABCDEF0});
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(9'd2);
    @(negedge clk);
    check("t1_stall_after_start", cpu_stall, 1'b1);
    @(posedge clk); #1;
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    byte_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (load_done) begin seen = 1; break; end
    end
    check("t1_done_seen", seen, 1'b1);
    check("t1_stall_in_done", cpu_stall, 1'b1);
    @(negedge clk);
    check("t1_stall_after_done", cpu_stall, 1'b0);
    check("t1_done_single", load_done, 1'b0);
    check("t1_writes", 64'(wr_cnt - wr0), 64'd2);
    @(posedge clk); #1;

    // load_len = 0 in IDLE is ignored; outputs keep the last write
    start_load(9'd0);
    @(negedge clk);
    check("len0_busy", busy, 1'b0);
    check("len0_stall", cpu_stall, 1'b0);
    check("len0_hold", {24'd0, mem_waddr, mem_wdata}, {32'd1, 32'h9ABCDEF0});
    @(posedge clk); #1;

    // load_start mid-load does not restart
    exp_q.push_back({8'd0, 32'hA1B2C3D4});
    exp_q.push_back({8'd1, 32'h0F1E2D3C});
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(9'd2);
    send_byte(8'hD4, 0); send_byte(8'hC3, 0); send_byte(8'hB2, 0);
    byte_valid = 1'b0;
    start_load(9'd1);
    send_byte(8'hA1, 0);
    send_word(32'h0F1E2D3C);
    byte_valid = 1'b0;
    wait_idle();
    check("midstart_writes", 64'(wr_cnt - wr0), 64'd2);
    check("midstart_done", 64'(done_cnt - dn0), 64'd1);

    // simultaneous abort and load_start in IDLE: load starts
    exp_q.push_back({8'd0, 32'h55AA33CC});
    abort = 1'b1;
    start_load(9'd1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 1'b1);
    @(posedge clk); #1;
    send_word(32'h55AA33CC);
    byte_valid = 1'b0;
    wait_idle();
    check("abort_start_err", load_err, 1'b0);

    // table-driven scenarios
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // reset mid-load after 3 bytes
    start_load(9'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          {56'd0, byte_ready, mem_we, cpu_stall, busy, load_done, load_err, 2'b00}, 64'd0);
    check("midrst_addr_data", {24'd0, mem_waddr, mem_wdata}, 64'd0);
    @(posedge clk); #1;
    exp_q.push_back({8'd0, 32'hCAFEF00D});
    wr0 = wr_cnt;
    start_load(9'd1);
    send_word(32'hCAFEF00D);
    byte_valid = 1'b0;
    wait_idle();
    check("postrst_writes", 64'(wr_cnt - wr0), 64'd1);

    repeat (3) @(posedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
